coherence_arbiter_n: RTL and testbench

COHERENCE_ARBITER_N -- requirements
Module: coherence_arbiter_n

---
 rtl/coherence_arbiter_n_if.sv | 27 ++
 rtl/coherence_arbiter_n.sv | 192 +++++++++++++++++++
 tb/tb_coherence_arbiter_n.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_arbiter_n_if.sv
// Core-side request/response bundle and RAM-side port for coherence_arbiter_n.
// Pure wiring, no latency.
// The slave modport is the arbiter; the master modport is the cores plus RAM.
interface coherence_arbiter_n_if #(
  parameter int CPUS   = 4,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]             iREN, dREN, dWEN, ccwrite, cctrans;
  logic [CPUS-1:0][WORD_W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]             iwait, dwait, ccwait, ccinv;
  logic [CPUS-1:0][WORD_W-1:0] iload, dload, ccsnoopaddr;
  logic                        ramREN, ramWEN;
  logic [WORD_W-1:0]           ramaddr, ramstore, ramload;
  logic [1:0]                  ramstate;

  modport slave (
    input  iREN, dREN, dWEN, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, dREN, dWEN, ccwrite, cctrans, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_arbiter_n.sv
// Snooping coherence arbiter: one winner per transaction, icache/dcache -> single RAM.
// Latency: IDLE + 1 state cycle for RAMWR/IREAD, + SNOOP cycle(s) for dREN; completes on ACCESS.
// Backpressure: holds state/strobes until ramstate==ACCESS; losers wait at request level. Macro RR_ARB_EN selects round-robin arbitration.
module coherence_arbiter_n #(
  parameter int CPUS   = 4,
  parameter int WORD_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  coherence_arbiter_n_if.slave bus
);
  localparam int         IW         = $clog2(CPUS);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_C2C, S_RAMRD, S_RAMWR, S_IREAD} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_winner, w_winner_nxt;
  logic [IW-1:0]   r_supplier, w_supplier_nxt;
  logic [IW-1:0]   w_dwin, w_iwin, w_dirty_idx;
  logic [CPUS-1:0] w_dreq, w_onehot, w_others;
  logic            w_held, w_done;

`ifdef RR_ARB_EN
  logic [IW-1:0]   r_dptr, w_dptr_nxt, r_iptr, w_iptr_nxt;

  // Index base+k folded back into 0..CPUS-1
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CPUS) s = s - CPUS;
    return IW'(s);
  endfunction

  // Successor of a core index, CPUS-1 wraps to 0
  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    if (v == IW'(CPUS - 1)) return '0;
    return v + IW'(1);
  endfunction
`endif

  // Per-class winner: round-robin from the pointer, or lowest index
  always_comb begin
    w_dreq = bus.dREN | bus.dWEN;
    w_dwin = '0;
    w_iwin = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
`ifdef RR_ARB_EN
      if (w_dreq[wrap_idx(r_dptr, k)])   w_dwin = wrap_idx(r_dptr, k);
      if (bus.iREN[wrap_idx(r_iptr, k)]) w_iwin = wrap_idx(r_iptr, k);
`else
      if (w_dreq[k])   w_dwin = IW'(k);
      if (bus.iREN[k]) w_iwin = IW'(k);
`endif
    end
  end

  // Non-winner mask, lowest dirty snooper, and whether the winner still wants service
  always_comb begin
    w_onehot           = '0;
    w_onehot[r_winner] = 1'b1;
    w_others           = ~w_onehot;
    w_dirty_idx        = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (bus.ccwrite[k] && w_others[k]) w_dirty_idx = IW'(k);
    end
    case (r_state)
      S_RAMWR: w_held = bus.dWEN[r_winner];
      S_IREAD: w_held = bus.iREN[r_winner];
      default: w_held = bus.dREN[r_winner];
    endcase
    w_done = w_held && (bus.ramstate == RAM_ACCESS) &&
             (r_state inside {S_C2C, S_RAMRD, S_RAMWR, S_IREAD});
  end

  // State, winner, supplier and pointer registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_winner   <= '0;
      r_supplier <= '0;
`ifdef RR_ARB_EN
      r_dptr     <= '0;
      r_iptr     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_winner   <= w_winner_nxt;
      r_supplier <= w_supplier_nxt;
`ifdef RR_ARB_EN
      r_dptr     <= w_dptr_nxt;
      r_iptr     <= w_iptr_nxt;
`endif
    end
  end

  // Next-state: arbitrate in IDLE, resolve snoop, finish on ACCESS, abort on drop
  always_comb begin
    w_state_nxt    = r_state;
    w_winner_nxt   = r_winner;
    w_supplier_nxt = r_supplier;
`ifdef RR_ARB_EN
    w_dptr_nxt     = r_dptr;
    w_iptr_nxt     = r_iptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (|w_dreq) begin
          w_winner_nxt = w_dwin;
          w_state_nxt  = bus.dWEN[w_dwin] ? S_RAMWR : S_SNOOP;
        end else if (|bus.iREN) begin
          w_winner_nxt = w_iwin;
          w_state_nxt  = S_IREAD;
        end
      end
      S_SNOOP: begin
        if (!w_held) begin
          w_state_nxt = S_IDLE;
        end else if (!(|(bus.cctrans & w_others))) begin
          if (|(bus.ccwrite & w_others)) begin
            w_state_nxt    = S_C2C;
            w_supplier_nxt = w_dirty_idx;
          end else begin
            w_state_nxt = S_RAMRD;
          end
        end
      end
      default: begin
        if (!w_held) begin
          w_state_nxt = S_IDLE;
        end else if (w_done) begin
          w_state_nxt = S_IDLE;
`ifdef RR_ARB_EN
          if (r_state == S_IREAD) w_iptr_nxt = inc_wrap(r_winner);
          else                    w_dptr_nxt = inc_wrap(r_winner);
`endif
        end
      end
    endcase
  end

  // Output decode: strobes, waits and data steering from state, winner and ramstate
  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    case (r_state)
      S_SNOOP: begin
        bus.ccwait = w_others;
        bus.ccinv  = w_others & {CPUS{bus.ccwrite[r_winner]}};
        for (int k = 0; k < CPUS; k++) begin
          if (w_others[k]) bus.ccsnoopaddr[k] = bus.daddr[r_winner];
        end
      end
      S_C2C: begin
        bus.ccwait          = w_others;
        bus.ramWEN          = 1'b1;
        bus.ramaddr         = bus.daddr[r_winner];
        bus.ramstore        = bus.dstore[r_supplier];
        bus.dload[r_winner] = bus.dstore[r_supplier];
        if (w_done) bus.dwait[r_winner] = 1'b0;
      end
      S_RAMRD: begin
        bus.ramREN          = 1'b1;
        bus.ramaddr         = bus.daddr[r_winner];
        bus.dload[r_winner] = bus.ramload;
        if (w_done) bus.dwait[r_winner] = 1'b0;
      end
      S_RAMWR: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr[r_winner];
        bus.ramstore = bus.dstore[r_winner];
        if (w_done) bus.dwait[r_winner] = 1'b0;
      end
      S_IREAD: begin
        bus.ramREN          = 1'b1;
        bus.ramaddr         = bus.iaddr[r_winner];
        bus.iload[r_winner] = bus.ramload;
        if (w_done) bus.iwait[r_winner] = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherence_arbiter_n.sv
// Self-checking bench for coherence_arbiter_n: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbitration and snoop rules.
module tb_coherence_arbiter_n;
  localparam int CPUS   = 4;
  localparam int WORD_W = 32;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  coherence_arbiter_n_if #(.CPUS(CPUS), .WORD_W(WORD_W)) bus ();

  coherence_arbiter_n #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  // ---------------- reference model ----------------
  // Current transaction: who is served, what kind, and where its data comes from.
  bit t_active, t_instr, t_write, t_snoop, t_cache;
  int t_core, t_sup;
  int m_dptr = 0, m_iptr = 0;

  logic [CPUS-1:0]             e_iwait, e_dwait, e_ccwait, e_ccinv;
  logic [CPUS-1:0][WORD_W-1:0] e_iload, e_dload, e_snoop;
  logic                        e_ramREN, e_ramWEN;
  logic [WORD_W-1:0]           e_ramaddr, e_ramstore;
  bit                          m_held, m_done, m_busy;
  int                          m_dirty;

  function automatic int pick(input logic [CPUS-1:0] req, input int ptr);
    int idx;
    for (int k = 0; k < CPUS; k++) begin
      idx = ((RR ? ptr : 0) + k) % CPUS;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  always @(negedge CLK) begin
    e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
    e_iload = '0; e_dload = '0; e_snoop = '0;
    e_ramREN = 1'b0; e_ramWEN = 1'b0; e_ramaddr = '0; e_ramstore = '0;
    m_held = 1'b0; m_done = 1'b0;
    if (t_active) begin
      m_held = t_instr ? bus.iREN[t_core] : (t_write ? bus.dWEN[t_core] : bus.dREN[t_core]);
      if (t_snoop) begin
        for (int i = 0; i < CPUS; i++) if (i != t_core) begin
          e_ccwait[i] = 1'b1;
          e_ccinv[i]  = bus.ccwrite[t_core];
          e_snoop[i]  = bus.daddr[t_core];
        end
      end else begin
        if (t_instr) begin
          e_ramREN = 1'b1; e_ramaddr = bus.iaddr[t_core]; e_iload[t_core] = bus.ramload;
        end else begin
          e_ramaddr = bus.daddr[t_core];
          if (t_write) begin
            e_ramWEN = 1'b1; e_ramstore = bus.dstore[t_core];
          end else if (t_cache) begin
            e_ramWEN = 1'b1; e_ramstore = bus.dstore[t_sup]; e_dload[t_core] = bus.dstore[t_sup];
            for (int i = 0; i < CPUS; i++) if (i != t_core) e_ccwait[i] = 1'b1;
          end else begin
            e_ramREN = 1'b1; e_dload[t_core] = bus.ramload;
          end
        end
        m_done = m_held && (bus.ramstate == 2'd2);
        if (m_done) begin
          if (t_instr) e_iwait[t_core] = 1'b0;
          else         e_dwait[t_core] = 1'b0;
        end
      end
    end

    chk("iwait", bus.iwait, e_iwait);
    chk("dwait", bus.dwait, e_dwait);
    chk("ccwait", bus.ccwait, e_ccwait);
    chk("ccinv", bus.ccinv, e_ccinv);
    chk("iload", bus.iload, e_iload);
    chk("dload", bus.dload, e_dload);
    chk("ccsnoopaddr", bus.ccsnoopaddr, e_snoop);
    chk("ramREN", bus.ramREN, e_ramREN);
    chk("ramWEN", bus.ramWEN, e_ramWEN);
    chk("ramaddr", bus.ramaddr, e_ramaddr);
    chk("ramstore", bus.ramstore, e_ramstore);

    // Advance to what the coming rising edge produces (inputs are stable until then).
    if (RST) begin
      t_active = 1'b0; m_dptr = 0; m_iptr = 0;
    end else if (!t_active) begin
      if ((bus.dREN | bus.dWEN) != '0) begin
        t_core   = pick(bus.dREN | bus.dWEN, m_dptr);
        t_active = 1'b1; t_instr = 1'b0; t_cache = 1'b0;
        t_write  = bus.dWEN[t_core];
        t_snoop  = !t_write;
      end else if (bus.iREN != '0) begin
        t_core   = pick(bus.iREN, m_iptr);
        t_active = 1'b1; t_instr = 1'b1; t_write = 1'b0; t_snoop = 1'b0; t_cache = 1'b0;
      end
    end else if (!m_held) begin
      t_active = 1'b0;
    end else if (t_snoop) begin
      m_busy = 1'b0; m_dirty = -1;
      for (int i = 0; i < CPUS; i++) if (i != t_core) begin
        if (bus.cctrans[i]) m_busy = 1'b1;
        if (bus.ccwrite[i] && m_dirty < 0) m_dirty = i;
      end
      if (!m_busy) begin
        t_snoop = 1'b0;
        if (m_dirty >= 0) begin t_cache = 1'b1; t_sup = m_dirty; end
      end
    end else if (m_done) begin
      t_active = 1'b0;
      if (t_instr) m_iptr = (t_core + 1) % CPUS;
      else         m_dptr = (t_core + 1) % CPUS;
    end
  end

  // ---------------- stimulus ----------------
  int r;
  initial begin
    RST = 1'b1;
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.ccwrite = '0; bus.cctrans = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = 2'd0;

    // reset outputs
    look();
    chk("rst_iwait", bus.iwait, 4'hF);
    chk("rst_dwait", bus.dwait, 4'hF);
    chk("rst_ccwait", bus.ccwait, 4'h0);
    chk("rst_ramREN", bus.ramREN, 1'b0);
    chk("rst_dload", bus.dload, 128'h0);

    // core2 read, clean snoop, ACCESS on the 2nd RAMRD cycle
    step(); RST = 1'b0; bus.daddr[2] = 32'h100; bus.dREN = 4'b0100; bus.ramload = 32'hDEADBEEF;
    look(); chk("s30_idle_dwait", bus.dwait, 4'hF);
    step(); look();
    chk("s30_snoop_ccwait", bus.ccwait, 4'b1011);
    chk("s30_snoopaddr0", bus.ccsnoopaddr[0], 32'h100);
    step(); look();
    chk("s30_rd1_ramREN", bus.ramREN, 1'b1);
    chk("s30_rd1_dwait", bus.dwait, 4'hF);
    step(); bus.ramstate = 2'd2; look();
    chk("s30_done_dwait", bus.dwait, 4'b1011);
    chk("s30_done_dload2", bus.dload[2], 32'hDEADBEEF);
    step(); bus.dREN = '0; bus.ramstate = 2'd0; look();
    chk("s30_after_dwait", bus.dwait, 4'hF);
    // data pointer now 3: cores 0 and 3 contend
    bus.dREN = 4'b1001;
    step(); look();
    chk("s30_ptr_ccwait", bus.ccwait, RR ? 4'b0111 : 4'b1110);
    step(); bus.ramstate = 2'd2; look();
    chk("s30_ptr_dwait", bus.dwait, RR ? 4'b0111 : 4'b1110);
    step(); bus.dREN = '0; bus.ramstate = 2'd0;

    // core0 read-exclusive, core3 busy two snoop cycles then supplies dirty line
    bus.dREN = 4'b0001; bus.ccwrite = 4'b0001; bus.cctrans = 4'b1000; bus.daddr[0] = 32'h200;
    look();
    step(); look();
    chk("s31_ccinv", bus.ccinv, 4'b1110);
    chk("s31_sn1_ccwait", bus.ccwait, 4'b1110);
    step(); look(); chk("s31_sn2_ccwait", bus.ccwait, 4'b1110);
    step(); bus.cctrans = '0; bus.ccwrite = 4'b1001; bus.dstore[3] = 32'h12345678; look();
    chk("s31_sn3_ccwait", bus.ccwait, 4'b1110);
    chk("s31_sn3_ramWEN", bus.ramWEN, 1'b0);
    step(); bus.ramstate = 2'd2; look();
    chk("s31_c2c_ramWEN", bus.ramWEN, 1'b1);
    chk("s31_c2c_ramstore", bus.ramstore, 32'h12345678);
    chk("s31_c2c_dload0", bus.dload[0], 32'h12345678);
    chk("s31_c2c_dwait", bus.dwait, 4'b1110);
    step(); bus.dREN = '0; bus.ccwrite = '0; bus.ramstate = 2'd0;

    // core1 write moves data pointer to 2; then cores 1 and 3 read together
    bus.dWEN = 4'b0010; bus.daddr[1] = 32'h300; bus.dstore[1] = 32'hCAFE0001;
    look();
    step(); bus.ramstate = 2'd2; look();
    chk("s32_wr_ramstore", bus.ramstore, 32'hCAFE0001);
    chk("s32_wr_dwait", bus.dwait, 4'b1101);
    step(); bus.dWEN = '0; bus.ramstate = 2'd0; bus.dREN = 4'b1010; look();
    step(); look(); chk("s32_first_ccwait", bus.ccwait, RR ? 4'b0111 : 4'b1101);
    step(); bus.ramstate = 2'd2; look();
    chk("s32_first_dwait", bus.dwait, RR ? 4'b0111 : 4'b1101);
    step(); bus.dREN = RR ? 4'b0010 : 4'b1000; bus.ramstate = 2'd0; look();
    step(); look(); chk("s32_second_ccwait", bus.ccwait, RR ? 4'b1101 : 4'b0111);
    step(); bus.ramstate = 2'd2; look();
    chk("s32_second_dwait", bus.dwait, RR ? 4'b1101 : 4'b0111);
    step(); bus.dREN = '0; bus.ramstate = 2'd0;

    // core1 fetch vs core0 write: write goes first
    bus.iREN = 4'b0010; bus.dWEN = 4'b0001; bus.daddr[0] = 32'h400; bus.iaddr[1] = 32'h500;
    look(); chk("s33_idle_iwait", bus.iwait, 4'hF);
    step(); look();
    chk("s33_wr_ramWEN", bus.ramWEN, 1'b1);
    chk("s33_wr_iwait", bus.iwait, 4'hF);
    step(); bus.ramstate = 2'd2; look();
    chk("s33_wr_dwait", bus.dwait, 4'b1110);
    chk("s33_wr_iwait2", bus.iwait, 4'hF);
    step(); bus.dWEN = '0; bus.ramstate = 2'd0; look();
    step(); bus.ramload = 32'hA5A50001; look();
    chk("s33_ird_ramaddr", bus.ramaddr, 32'h500);
    chk("s33_ird_iwait", bus.iwait, 4'hF);
    step(); bus.ramstate = 2'd2; look();
    chk("s33_ird_done_iwait", bus.iwait, 4'b1101);
    chk("s33_ird_iload1", bus.iload[1], 32'hA5A50001);
    step(); bus.iREN = '0; bus.ramstate = 2'd0;

    // reset while RAMRD is stalled on BUSY
    bus.dREN = 4'b0100; bus.daddr[2] = 32'h600; bus.ramstate = 2'd1;
    look();
    step(); look();
    step(); look(); chk("s34_rd_ramREN", bus.ramREN, 1'b1);
    step(); RST = 1'b1; look(); chk("s34_rst_ramREN", bus.ramREN, 1'b1);
    step(); look();
    chk("s34_post_ramREN", bus.ramREN, 1'b0);
    chk("s34_post_dwait", bus.dwait, 4'hF);
    step(); RST = 1'b0; bus.dREN = '0; bus.ramstate = 2'd0;

    // winner drops in RAMRD; then ERROR stalls a read for 5 cycles
    bus.dREN = 4'b0010; bus.daddr[1] = 32'h700;
    look();
    step(); look();
    step(); look(); chk("s35_rd_ramREN", bus.ramREN, 1'b1);
    step(); bus.dREN = '0; look(); chk("s35_drop_dwait", bus.dwait, 4'hF);
    step(); look(); chk("s35_idle_ramREN", bus.ramREN, 1'b0);
    bus.dREN = 4'b0101; bus.daddr[0] = 32'h800;
    step(); look(); chk("s35_ptr_ccwait", bus.ccwait, 4'b1110);
    step(); bus.ramstate = 2'd3;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("s35_err_ramREN", bus.ramREN, 1'b1);
      chk("s35_err_dwait", bus.dwait, 4'hF);
      step();
    end
    bus.ramstate = 2'd2; look();
    chk("s35_done_dwait", bus.dwait, 4'b1110);
    step(); bus.dREN = '0; bus.ramstate = 2'd0;

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      RST = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 7) == 0) bus.dREN[c] = ~bus.dREN[c];
        if ($urandom_range(0, 11) == 0) bus.dWEN[c] = ~bus.dWEN[c];
        if ($urandom_range(0, 7) == 0) bus.iREN[c] = ~bus.iREN[c];
        bus.cctrans[c] = ($urandom_range(0, 3) == 0);
        bus.ccwrite[c] = ($urandom_range(0, 2) == 0);
        bus.daddr[c]   = $urandom;
        bus.iaddr[c]   = $urandom;
        bus.dstore[c]  = $urandom;
      end
      bus.ramload = $urandom;
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 4) ? 2'd2 : (r < 7) ? 2'd1 : (r < 9) ? 2'd0 : 2'd3;
    end
    look();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
